// File: rtl/disp_traceback.sv
// Traceback engine for the 8-state x 128-step survivor-decision memory.
// Walks backwards from a given step/state, emitting one decoded bit every two clocks.
module disp_traceback #(
  parameter int TB_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] start_step,
  input  logic [2:0] start_state,
  output logic [9:0] mem_addr,
  input  logic       mem_d,
  output logic       bit_o,
  output logic       bit_valid,
  output logic       done,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for start
  // ADDR  | memory is capturing mem_addr
  // DATA  | mem_d valid, predecessor state formed and bit emitted
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state, state_nxt;
  logic [6:0] cur_step, cur_step_nxt;
  logic [2:0] cur_state, cur_state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [9:0] mem_addr_nxt;
  logic       bit_nxt, bit_valid_nxt, done_nxt, busy_nxt;
  logic       accept, last;
  logic [6:0] prev_step;
  logic [2:0] prev_state;

  // done is still high in the first IDLE cycle, so a start there is dropped
  assign accept     = (state == IDLE) && start && !done;
  assign last       = (cnt == 8'(TB_LEN - 1));
  assign prev_step  = cur_step - 7'd1;
  assign prev_state = {cur_state[1:0], mem_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADDR;
      ADDR:    state_nxt = DATA;
      DATA:    state_nxt = last ? IDLE : ADDR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_step_nxt  = cur_step;
    cur_state_nxt = cur_state;
    cnt_nxt       = cnt;
    mem_addr_nxt  = mem_addr;
    bit_nxt       = bit_o;
    bit_valid_nxt = 1'b0;
    done_nxt      = 1'b0;
    busy_nxt      = busy;
    case (state)
      IDLE: begin
        if (accept) begin
          cur_step_nxt  = start_step;
          cur_state_nxt = start_state;
          cnt_nxt       = 8'd0;
          mem_addr_nxt  = {start_step, start_state};
          busy_nxt      = 1'b1;
        end
      end
      DATA: begin
        bit_nxt       = cur_state[2];
        bit_valid_nxt = 1'b1;
        cur_state_nxt = prev_state;
        cur_step_nxt  = prev_step;
        mem_addr_nxt  = {prev_step, prev_state};
        cnt_nxt       = cnt + 8'd1;
        if (last) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_step  <= '0;
      cur_state <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      bit_o     <= 1'b0;
      bit_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cur_step  <= cur_step_nxt;
      cur_state <= cur_state_nxt;
      cnt       <= cnt_nxt;
      mem_addr  <= mem_addr_nxt;
      bit_o     <= bit_nxt;
      bit_valid <= bit_valid_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
